// File: rtl/ita_timer_slave_pkg.sv
// Shared constants for the ITA timer slave: register offsets, CTRL bit indices
// and the handshake FSM encoding.
package ita_timer_slave_pkg;

  localparam int ITA_ADDR_W = 32;
  localparam int ITA_DATA_W = 32;

  localparam logic [4:0] ITA_TMR_OFS_CTRL     = 5'h00;
  localparam logic [4:0] ITA_TMR_OFS_COUNT_LO = 5'h04;
  localparam logic [4:0] ITA_TMR_OFS_COUNT_HI = 5'h08;
  localparam logic [4:0] ITA_TMR_OFS_CMP_LO   = 5'h0C;
  localparam logic [4:0] ITA_TMR_OFS_CMP_HI   = 5'h10;
  localparam logic [4:0] ITA_TMR_OFS_STATUS   = 5'h14;

  localparam int ITA_TMR_NUM_REGS  = 6;
  localparam int ITA_TMR_CTRL_EN   = 0;
  localparam int ITA_TMR_CTRL_IE   = 1;
  localparam int ITA_TMR_STATUS_PEND = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } ita_state_e;

  // Word index of a byte offset inside the 32-byte window.
  function automatic logic [2:0] ofs_to_idx(input logic [4:0] ofs);
    return ofs[4:2];
  endfunction

endpackage

// File: rtl/ita_timer_slave_if.sv
// ITA load/store port between the LSU (master) and a memory-mapped responder (slave).
interface ita_timer_slave_if;
  import ita_timer_slave_pkg::*;

  logic                  ita_valid;
  logic                  ita_wr;
  logic                  ita_rd;
  logic [ITA_ADDR_W-1:0] ita_addr;
  logic [ITA_DATA_W-1:0] ita_wdata;
  logic [ITA_DATA_W-1:0] ita_rdata;
  logic                  ita_ready;
  logic                  ita_err;

  modport master (
    output ita_valid, ita_wr, ita_rd, ita_addr, ita_wdata,
    input  ita_rdata, ita_ready, ita_err
  );

  modport slave (
    input  ita_valid, ita_wr, ita_rd, ita_addr, ita_wdata,
    output ita_rdata, ita_ready, ita_err
  );

endinterface

// File: rtl/ita_timer_slave_core.sv
// Timer datapath: prescaler, 64-bit counter, 64-bit compare and sticky pend flag,
// updated through one write strobe per register word.
module ita_timer_slave_core
  import ita_timer_slave_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ITA_TMR_NUM_REGS-1:0] reg_we,
  input  logic [ITA_DATA_W-1:0]       wdata,
  output logic [1:0]                  ctrl,
  output logic [63:0]                 count,
  output logic [63:0]                 cmp,
  output logic                        pend
);

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  logic [1:0]  ctrl_reg,  ctrl_next;
  logic [15:0] presc_reg, presc_next;
  logic [63:0] count_reg, count_next;
  logic [63:0] cmp_reg,   cmp_next;
  logic        pend_reg,  pend_next;
  logic        tick;
  logic        en;

  assign en   = ctrl_reg[ITA_TMR_CTRL_EN];
  assign tick = en && (presc_reg == PRESC_LAST);

  always_comb begin
    ctrl_next  = ctrl_reg;
    presc_next = presc_reg;
    count_next = count_reg;
    cmp_next   = cmp_reg;

    if (en) presc_next = tick ? 16'd0 : presc_reg + 16'd1;

    // Software writes are applied after the tick so they replace it entirely.
    if (tick)      count_next = count_reg + 64'd1;
    if (reg_we[1]) count_next = {count_reg[63:32], wdata};
    if (reg_we[2]) count_next = {wdata, count_reg[31:0]};

    if (reg_we[0]) ctrl_next = wdata[1:0];
    if (reg_we[3]) cmp_next  = {cmp_reg[63:32], wdata};
    if (reg_we[4]) cmp_next  = {wdata, cmp_reg[31:0]};

    // Set has priority over write-1-clear.
    pend_next = (pend_reg && !(reg_we[5] && wdata[ITA_TMR_STATUS_PEND]))
              || (en && (count_reg >= cmp_reg));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_reg  <= 2'b00;
      presc_reg <= 16'd0;
      count_reg <= 64'd0;
      cmp_reg   <= 64'hFFFF_FFFF_FFFF_FFFF;
      pend_reg  <= 1'b0;
    end else begin
      ctrl_reg  <= ctrl_next;
      presc_reg <= presc_next;
      count_reg <= count_next;
      cmp_reg   <= cmp_next;
      pend_reg  <= pend_next;
    end
  end

  assign ctrl  = ctrl_reg;
  assign count = count_reg;
  assign cmp   = cmp_reg;
  assign pend  = pend_reg;

endmodule

// File: rtl/ita_timer_slave.sv
// ITA responder wrapping the timer core: request latch, wait-state FSM,
// address decode and read mux.
module ita_timer_slave
  import ita_timer_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
  parameter int          WAIT_CYCLES = 1,
  parameter int          PRESCALE    = 1
) (
  input  logic               clk,
  input  logic               rst,
  ita_timer_slave_if.slave   ita,
  output logic               timer_irq
);

  localparam logic [3:0] WAIT_CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  ita_state_e      state_reg, state_next;
  logic [3:0]      wait_cnt_reg, wait_cnt_next;
  logic            req_wr_reg, req_wr_next;
  logic [2:0]      req_idx_reg, req_idx_next;
  logic            req_in_win_reg, req_in_win_next;
  logic [31:0]     req_wdata_reg, req_wdata_next;

  logic [31:0]     ofs_full;
  logic            unused_ofs;
  logic            wr_fire;
  logic            resp;
  logic [ITA_TMR_NUM_REGS-1:0] reg_we;
  logic [31:0]     rd_word;

  logic [1:0]      ctrl;
  logic [63:0]     count;
  logic [63:0]     cmp;
  logic            pend;

  // Unsigned difference: anything below the base wraps high and lands out of window.
  assign ofs_full   = ita.ita_addr - BASE_ADDR;
  assign unused_ofs = ^ofs_full[1:0];

  always_comb begin
    state_next      = state_reg;
    wait_cnt_next   = wait_cnt_reg;
    req_wr_next     = req_wr_reg;
    req_idx_next    = req_idx_reg;
    req_in_win_next = req_in_win_reg;
    req_wdata_next  = req_wdata_reg;

    case (state_reg)
      ST_IDLE: begin
        if (ita.ita_valid && (ita.ita_wr || ita.ita_rd)) begin
          req_wr_next     = ita.ita_wr;
          req_idx_next    = ofs_to_idx(ofs_full[4:0]);
          req_in_win_next = (ofs_full[31:5] == 27'd0);
          req_wdata_next  = ita.ita_wdata;
          wait_cnt_next   = WAIT_CNT_INIT;
          state_next      = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (!ita.ita_valid)           state_next = ST_IDLE;
        else if (wait_cnt_reg == 4'd0) state_next = ST_RESP;
        else                           wait_cnt_next = wait_cnt_reg - 4'd1;
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      wait_cnt_reg   <= 4'd0;
      req_wr_reg     <= 1'b0;
      req_idx_reg    <= 3'd0;
      req_in_win_reg <= 1'b0;
      req_wdata_reg  <= 32'd0;
    end else begin
      state_reg      <= state_next;
      wait_cnt_reg   <= wait_cnt_next;
      req_wr_reg     <= req_wr_next;
      req_idx_reg    <= req_idx_next;
      req_in_win_reg <= req_in_win_next;
      req_wdata_reg  <= req_wdata_next;
    end
  end

  assign resp    = (state_reg == ST_RESP);
  assign wr_fire = resp && req_wr_reg && req_in_win_reg;

  // Writes commit on the edge that closes the RESP cycle.
  genvar gi;
  generate
    for (gi = 0; gi < ITA_TMR_NUM_REGS; gi++) begin : g_we
      assign reg_we[gi] = wr_fire && (req_idx_reg == 3'(gi));
    end
  endgenerate

  always_comb begin
    rd_word = 32'd0;
    case (req_idx_reg)
      ofs_to_idx(ITA_TMR_OFS_CTRL):     rd_word = {30'd0, ctrl};
      ofs_to_idx(ITA_TMR_OFS_COUNT_LO): rd_word = count[31:0];
      ofs_to_idx(ITA_TMR_OFS_COUNT_HI): rd_word = count[63:32];
      ofs_to_idx(ITA_TMR_OFS_CMP_LO):   rd_word = cmp[31:0];
      ofs_to_idx(ITA_TMR_OFS_CMP_HI):   rd_word = cmp[63:32];
      ofs_to_idx(ITA_TMR_OFS_STATUS):   rd_word = {31'd0, pend};
      default:                          rd_word = 32'd0;
    endcase
  end

  assign ita.ita_ready = resp;
  assign ita.ita_err   = resp && !req_in_win_reg;
  assign ita.ita_rdata = (resp && req_in_win_reg && !req_wr_reg) ? rd_word : 32'd0;

  ita_timer_slave_core #(
    .PRESCALE (PRESCALE)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .reg_we (reg_we),
    .wdata  (req_wdata_reg),
    .ctrl   (ctrl),
    .count  (count),
    .cmp    (cmp),
    .pend   (pend)
  );

  assign timer_irq = pend && ctrl[ITA_TMR_CTRL_IE];

endmodule

// File: tb/tb_ita_timer_slave.sv
// Directed bench for ita_timer_slave: one instance with 1 wait state, one with 3.
module tb_ita_timer_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq_w1, irq_w3;

  int n_total = 0;
  int n_bad   = 0;

  ita_timer_slave_if if_w1 ();
  ita_timer_slave_if if_w3 ();

  ita_timer_slave #(.BASE_ADDR(32'h0200_0000), .WAIT_CYCLES(1), .PRESCALE(1)) u_dut_w1 (
    .clk(clk), .rst(rst), .ita(if_w1.slave), .timer_irq(irq_w1)
  );

  ita_timer_slave #(.BASE_ADDR(32'h0200_0000), .WAIT_CYCLES(3), .PRESCALE(1)) u_dut_w3 (
    .clk(clk), .rst(rst), .ita(if_w3.slave), .timer_irq(irq_w3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic w, input logic r,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 1) begin
      if_w1.ita_valid = v; if_w1.ita_wr = w; if_w1.ita_rd = r;
      if_w1.ita_addr = a;  if_w1.ita_wdata = d;
    end else begin
      if_w3.ita_valid = v; if_w3.ita_wr = w; if_w3.ita_rd = r;
      if_w3.ita_addr = a;  if_w3.ita_wdata = d;
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 1) ? if_w1.ita_ready : if_w3.ita_ready;
  endfunction

  // Full transaction; lat counts negedges from request drive to the ready sample.
  task automatic xact(input int sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rdat, output logic e, output int lat);
    bit seen = 1'b0;
    rdat = 32'd0; e = 1'b0; lat = 0;
    @(posedge clk); #1;
    drive(sel, 1'b1, w, !w, a, d);
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (rdy(sel)) begin
        seen = 1'b1;
        lat  = i;
        rdat = (sel == 1) ? if_w1.ita_rdata : if_w3.ita_rdata;
        e    = (sel == 1) ? if_w1.ita_err   : if_w3.ita_err;
      end
    end
    check("ready_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("ready_one_cycle", 64'(rdy(sel)), 64'd0);
    $display("xact w%0d %s addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
             sel, w ? "WR" : "RD", a, d, rdat, e, lat);
  endtask

  task automatic rd_chk(input int sel, input string tag, input logic [31:0] a,
                        input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] rdat; logic e; int lat;
    xact(sel, 1'b0, a, 32'd0, rdat, e, lat);
    check({tag, "_rdata"}, 64'(rdat), 64'(exp_d));
    check({tag, "_err"},   64'(e),    64'(exp_e));
  endtask

  task automatic wr_chk(input int sel, input string tag, input logic [31:0] a,
                        input logic [31:0] d, input logic exp_e);
    logic [31:0] rdat; logic e; int lat;
    xact(sel, 1'b1, a, d, rdat, e, lat);
    check({tag, "_err"}, 64'(e), 64'(exp_e));
  endtask

  localparam logic [31:0] A_CTRL  = 32'h0200_0000;
  localparam logic [31:0] A_CLO   = 32'h0200_0004;
  localparam logic [31:0] A_CHI   = 32'h0200_0008;
  localparam logic [31:0] A_MLO   = 32'h0200_000C;
  localparam logic [31:0] A_MHI   = 32'h0200_0010;
  localparam logic [31:0] A_STAT  = 32'h0200_0014;

  initial begin
    logic [31:0] rdat;
    logic        e;
    int          lat;
    int          hit;
    bit          seen;

    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(3, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(if_w1.ita_ready), 64'd0);
    check("rst_err",   64'(if_w1.ita_err),   64'd0);
    check("rst_rdata", 64'(if_w1.ita_rdata), 64'd0);
    check("rst_irq",   64'(irq_w1),          64'd0);

    // Read CMP_HI after reset; latency includes the idle cycle before acceptance.
    xact(1, 1'b0, A_MHI, 32'd0, rdat, e, lat);
    check("cmphi_rst_rdata", 64'(rdat), 64'hFFFF_FFFF);
    check("cmphi_rst_err",   64'(e),    64'd0);
    check("lat_w1",          64'(lat),  64'd3);
    xact(3, 1'b0, A_MHI, 32'd0, rdat, e, lat);
    check("lat_w3",          64'(lat),  64'd5);

    // Compare = 5, enable with interrupt: pend appears 6 edges after the CTRL commit.
    wr_chk(1, "wr_cmplo", A_MLO, 32'd5, 1'b0);
    wr_chk(1, "wr_cmphi", A_MHI, 32'd0, 1'b0);
    wr_chk(1, "wr_ctrl",  A_CTRL, 32'd3, 1'b0);
    hit = 0;
    for (int k = 1; k <= 20 && hit == 0; k++) begin
      @(negedge clk);
      if (irq_w1) hit = k;
    end
    check("irq_delay", 64'(hit), 64'd6);
    rd_chk(1, "status_set", A_STAT, 32'd1, 1'b0);
    wr_chk(1, "w1c_status", A_STAT, 32'd1, 1'b0);
    rd_chk(1, "status_sticky", A_STAT, 32'd1, 1'b0);
    check("irq_after_w1c", 64'(irq_w1), 64'd1);

    // 64-bit wrap: all-ones at commit, 0 on the next tick, then 1 per cycle.
    wr_chk(1, "wr_cnthi", A_CHI, 32'hFFFF_FFFF, 1'b0);
    wr_chk(1, "wr_cntlo", A_CLO, 32'hFFFF_FFFF, 1'b0);
    rd_chk(1, "cnthi_wrap", A_CHI, 32'd0, 1'b0);
    rd_chk(1, "cntlo_wrap", A_CLO, 32'd6, 1'b0);

    // Write beats the coincident tick: 100 at commit, +3 ticks until the read samples.
    wr_chk(1, "wr_cnt100", A_CLO, 32'd100, 1'b0);
    rd_chk(1, "cnt_write_wins", A_CLO, 32'd103, 1'b0);

    rd_chk(1, "out_of_win_rd", 32'h0300_0000, 32'd0, 1'b1);
    wr_chk(1, "out_of_win_wr", 32'h0300_000C, 32'h77, 1'b1);
    rd_chk(1, "cmplo_kept", A_MLO, 32'd5, 1'b0);
    rd_chk(1, "reserved_rd", 32'h0200_0018, 32'd0, 1'b0);
    wr_chk(1, "reserved_wr", 32'h0200_001C, 32'hAB, 1'b0);
    rd_chk(1, "ctrl_rd", A_CTRL, 32'd3, 1'b0);

    // Abort: valid drops in the second WAIT cycle of a CMP_LO write.
    @(posedge clk); #1;
    drive(3, 1'b1, 1'b1, 1'b0, A_MLO, 32'd7);
    @(posedge clk);
    @(posedge clk); #1;
    drive(3, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (if_w3.ita_ready) seen = 1'b1;
    end
    $display("xact w3 WR addr=%h wdata=%h aborted", A_MLO, 32'd7);
    check("abort_no_ready", 64'(seen), 64'd0);
    rd_chk(3, "abort_cmplo", A_MLO, 32'hFFFF_FFFF, 1'b0);

    // Reset in the middle of WAIT drops the transaction and restores reset state.
    wr_chk(3, "w3_ctrl", A_CTRL, 32'd3, 1'b0);
    wr_chk(3, "w3_cmphi", A_MHI, 32'h1234_5678, 1'b0);
    @(posedge clk); #1;
    drive(3, 1'b1, 1'b1, 1'b0, A_MLO, 32'd7);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(3, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (if_w3.ita_ready) seen = 1'b1;
    end
    $display("xact w3 WR addr=%h wdata=%h reset mid-wait", A_MLO, 32'd7);
    check("rst_mid_no_ready", 64'(seen), 64'd0);
    rd_chk(3, "rst_ctrl",  A_CTRL, 32'd0, 1'b0);
    rd_chk(3, "rst_cmplo", A_MLO,  32'hFFFF_FFFF, 1'b0);
    rd_chk(3, "rst_cmphi", A_MHI,  32'hFFFF_FFFF, 1'b0);
    rd_chk(3, "rst_cntlo", A_CLO,  32'd0, 1'b0);
    rd_chk(3, "rst_status", A_STAT, 32'd0, 1'b0);
    check("rst_irq_w3", 64'(irq_w3), 64'd0);
    check("rst_irq_w1", 64'(irq_w1), 64'd0);
    rd_chk(1, "rst_w1_ctrl",  A_CTRL, 32'd0, 1'b0);
    rd_chk(1, "rst_w1_cmplo", A_MLO,  32'hFFFF_FFFF, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ita_timer_slave.md
Name: ita_timer_slave

Overview:
- Responder end of the ITA load/store port driven by the LSU: accepts wr/rd/addr/wdata/valid and returns rdata/ready.
- Implements a memory-mapped 64-bit timer with compare and a write-1-clear interrupt flag, returned with a programmable number of wait states.
- Sits outside the core's memory top and is wired to the LSU ITA outputs and inputs; its interrupt feeds the core's interrupt logic.

Parameters:
- BASE_ADDR, 32'h0200_0000, base address of the 32-byte register window.
- WAIT_CYCLES, 1, cycles between request acceptance and the ready pulse (0..15).
- PRESCALE, 1, clk cycles per counter tick (1..65535).

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; synchronous, active-high.
- ita_valid  in  1  request valid from LSU.
- ita_wr  in  1  write request.
- ita_rd  in  1  read request.
- ita_addr  in  PC_SIZE(32)  byte address.
- ita_wdata  in  XLEN(32)  write data.
- ita_rdata  out  XLEN(32)  read data, valid only while ita_ready=1.
- ita_ready  out  1  single-cycle completion pulse.
- ita_err  out  1  access to an unmapped offset, qualified by ita_ready.
- timer_irq  out  1  level interrupt: STATUS.pend & CTRL.ie.

Behaviour:
- Reset (sync, active-high, clk edge): ita_ready=0, ita_err=0, ita_rdata=0, timer_irq=0, COUNT=0, CMP=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, STATUS=0, prescaler=0, FSM=IDLE.
  - Reset mid-transaction drops the transaction: no register update, no ready.
- Register map (offset = ita_addr - BASE_ADDR, word aligned; addr[1:0] ignored):
  - 0x00 CTRL: bit0 en, bit1 ie; other bits read 0.
  - 0x04 COUNT_LO.
  - 0x08 COUNT_HI.
  - 0x0C CMP_LO.
  - 0x10 CMP_HI.
  - 0x14 STATUS: bit0 pend; writing 1 clears it.
  - 0x18 and 0x1C: reserved, read 0, writes ignored, ita_err=0.
  - An address outside the window gives rdata=0, no write, ita_err=1.
- FSM states IDLE, WAIT, RESP:
  - IDLE: on ita_valid & (ita_wr|ita_rd), latch wr, offset, wdata and an in-window flag. Go to WAIT if WAIT_CYCLES>0, else RESP. A request with both wr and rd treats wr as dominant.
  - WAIT: the counter runs WAIT_CYCLES-1 down to 0, then go to RESP. If ita_valid falls during WAIT, abort to IDLE with no effect (LSU kill or commit trap).
  - RESP: assert ita_ready for exactly one cycle, together with ita_rdata and ita_err. A write commits at this clock edge, and the read value is sampled at the same edge before that commit. Return to IDLE.
  - Latency from accepting edge to the ready cycle is WAIT_CYCLES+1. Throughput is 1 request per WAIT_CYCLES+2 cycles, because IDLE does not accept a request during RESP.
- Counter:
  - When CTRL.en=1, the prescaler counts 0..PRESCALE-1. COUNT increments by 1 when the prescaler wraps, with a 64-bit wrap from all-ones to 0.
  - A software write to COUNT_LO/HI in the same cycle as a tick wins; the tick is lost.
  - Reading COUNT_LO does not snapshot COUNT_HI; software handles the torn read.
- Compare:
  - STATUS.pend is set on any cycle where COUNT >= CMP (unsigned 64-bit) and en=1. It is sticky.
  - A W1C in the same cycle as the set condition leaves pend set.
  - Writing a 0 bit to STATUS has no effect.

Decomposition:
- Shared package/defines file (mcu_defines): ITA_TMR_OFS_CTRL..ITA_TMR_OFS_STATUS offset constants, the CTRL bit indices, and the FSM state encoding localparams.
- Sub-module ita_timer_core: prescaler, 64-bit counter, compare and pend logic, with a write-strobe interface.
- The top level keeps the ITA handshake FSM and address decode.

Test Plan:
- Reset, then read 0x0200_0010 with WAIT_CYCLES=1 -> ita_ready pulses 2 cycles after acceptance, rdata=32'hFFFF_FFFF, ita_err=0.
- Write CMP_LO=5 and CMP_HI=0, then CTRL=3, with PRESCALE=1 -> COUNT reaches 5 within 5 cycles of the CTRL commit; the next cycle has STATUS.pend=1 and timer_irq=1. Write STATUS=1 while COUNT>=CMP -> pend stays 1.
- Write COUNT_LO=32'hFFFF_FFFF and COUNT_HI=32'hFFFF_FFFF with en=1 -> the next tick gives COUNT=0. Read COUNT_HI -> 0.
- Read 0x0300_0000 -> ready pulse with rdata=0 and ita_err=1; no register changes. Read 0x0200_0018 -> rdata=0, ita_err=0.
- Use WAIT_CYCLES=3 and drop ita_valid in the 2nd WAIT cycle of a write to CMP_LO=7 -> no ready; CMP_LO still reads 32'hFFFF_FFFF.
- Write COUNT_LO=100 on the same edge as a prescaler tick -> COUNT_LO reads 100, not 101. Assert rst mid-WAIT -> ready stays 0 and all registers return to their reset values.
